// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin arbiter that serialises per-core data
// memory accesses into one shared memory port, one access per 3 cycles.
// Ports: clk, rst_n, num_cores (enable count), req/wr/addr/wdata (per
// core, flattened), ack/rdata/grant_id/busy (to cores),
// mem_addr/mem_wdata/mem_rd/mem_wr/mem_rdata (to/from data memory).
`timescale 1ns/1ps
module core_mem_arbiter #(
    parameter int NUM_CORES = 16,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int CW        = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CW-1:0]               num_cores,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        wr,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic [4:0]                  grant_id,
    output logic                        busy,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_rd,
    output logic                        mem_wr,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t               state;
    logic [IW-1:0]        last;
    logic [IW-1:0]        sel;
    logic [IW-1:0]        win;
    logic [IW:0]          sum;
    logic                 found;
    logic                 wr_l;
    logic [NUM_CORES-1:0] en;
    logic [NUM_CORES-1:0] ereq;
    logic [DATA_W-1:0]    rdata_q;

    logic [ADDR_W-1:0] a_arr [NUM_CORES];
    logic [DATA_W-1:0] d_arr [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign a_arr[g] = addr[g*ADDR_W +: ADDR_W];
        assign d_arr[g] = wdata[g*DATA_W +: DATA_W];
    end

    // num_cores at or above NUM_CORES enables every port
    always_comb begin
        en = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            en[i] = (32'(num_cores) > 32'(i));
        end
    end

    assign ereq = req & en;

    // Round-robin: first requester above the previous winner, wrapping
    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            sum = {1'b0, last} + (IW+1)'(i);
            if (sum >= (IW+1)'(NUM_CORES)) begin
                sum = sum - (IW+1)'(NUM_CORES);
            end
            if (!found && ereq[sum[IW-1:0]]) begin
                found = 1'b1;
                win   = sum[IW-1:0];
            end
        end
    end

    // Read data comes straight from memory in the ack cycle and is
    // then held in rdata_q until the next read completes.
    assign rdata = (state == RESP && !wr_l) ? mem_rdata : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack       <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            busy      <= 1'b0;
            grant_id  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
            wr_l      <= 1'b0;
            sel       <= '0;
            last      <= IW'(NUM_CORES - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        sel       <= win;
                        grant_id  <= 5'(win);
                        mem_addr  <= a_arr[win];
                        mem_wdata <= d_arr[win];
                        wr_l      <= wr[win];
                        mem_wr    <= wr[win];
                        mem_rd    <= !wr[win];
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    ack    <= NUM_CORES'(1) << sel;
                    state  <= RESP;
                end
                RESP: begin
                    ack  <= '0;
                    busy <= 1'b0;
                    last <= sel;
                    if (!wr_l) begin
                        rdata_q <= mem_rdata;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed stimulus with scoreboard queues for
// memory strobes and acks, checked by an independent monitor.
`timescale 1ns/1ps
module tb_core_mem_arbiter;

    localparam int N  = 16;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int CW = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CW-1:0]   num_cores = '0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    wr = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic [4:0]      grant_id;
    logic            busy;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_rd;
    logic            mem_wr;
    logic [DW-1:0]   mem_rdata = '0;

    core_mem_arbiter #(
        .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .num_cores(num_cores),
        .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .grant_id(grant_id), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        int          core;
        int          cyc;
    } stb_t;

    typedef struct {
        int          core;
        logic [15:0] rd;
        int          cyc;
    } ack_t;

    stb_t sq[$];
    ack_t aq[$];

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    bit          drop   = 1'b1;
    logic [15:0] mem [256];

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: read data one cycle after mem_rd
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queues
    initial begin
        stb_t s;
        ack_t a;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_rd || mem_wr) begin
                    chk("strobe_excl", {31'd0, mem_rd & mem_wr}, 0);
                    if (sq.size() == 0) begin
                        chk("unexpected_strobe", {16'd0, mem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        s = sq.pop_front();
                        chk("strobe_wr", {31'd0, mem_wr}, {31'd0, s.w});
                        chk("mem_addr", {16'd0, mem_addr}, {16'd0, s.a});
                        if (s.w) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, s.d});
                        chk("grant_id", {27'd0, grant_id}, s.core);
                        chk("busy_access", {31'd0, busy}, 1);
                        if (s.cyc >= 0) chk("strobe_cycle", cyc, s.cyc);
                    end
                end
                if (|ack) begin
                    if (aq.size() == 0) begin
                        chk("unexpected_ack", {16'd0, ack}, 0);
                    end else begin
                        a = aq.pop_front();
                        chk("ack_onehot", {16'd0, ack}, 32'd1 << a.core);
                        chk("rdata", {16'd0, rdata}, {16'd0, a.rd});
                        chk("strobe_in_ack", {30'd0, mem_rd, mem_wr}, 0);
                        if (a.cyc >= 0) chk("ack_cycle", cyc, a.cyc);
                    end
                end
            end
        end
    end

    task automatic set_core(input int i, input bit w,
                            input logic [15:0] a, input logic [15:0] d);
        wr[i] = w;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic push(input int core, input bit w, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] rd,
                        input int sc, input int ac);
        sq.push_back('{w, a, d, core, sc});
        aq.push_back('{core, rd, ac});
    endtask

    // One cycle: sample ack, then after the edge drop acked requests
    task automatic step();
        logic [N-1:0] a;
        @(negedge clk);
        a = ack;
        @(posedge clk);
        #1;
        if (drop) req = req & ~a;
    endtask

    task automatic wait_done(input string nm, input int bound);
        int k;
        k = 0;
        while ((sq.size() != 0 || aq.size() != 0) && k < bound) begin
            step();
            k++;
        end
        checks++;
        if (sq.size() != 0 || aq.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: got %0d pending expected 0",
                     nm, sq.size() + aq.size());
            sq.delete();
            aq.delete();
        end
    endtask

    int e;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(16'hA000 + i);
        mem[8'h10] = 16'hBEEF;
        mem[8'h20] = 16'h5A5A;
        mem[8'h25] = 16'h7777;
        mem[8'h30] = 16'h1357;

        // Reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ack", {16'd0, ack}, 0);
        chk("rst_strobes", {30'd0, mem_rd, mem_wr}, 0);
        chk("rst_grant", {27'd0, grant_id}, 0);
        chk("rst_maddr", {16'd0, mem_addr}, 0);
        chk("rst_mwdata", {16'd0, mem_wdata}, 0);
        chk("rst_rdata", {16'd0, rdata}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Single read from core 2
        num_cores = 6'd4;
        set_core(2, 1'b0, 16'h0010, 16'h0000);
        e = cyc;
        push(2, 1'b0, 16'h0010, 16'h0, 16'hBEEF, e + 1, e + 2);
        req[2] = 1'b1;
        wait_done("read", 20);
        step();

        // Single write from core 0, rdata keeps 0xBEEF
        set_core(0, 1'b1, 16'h0003, 16'h1234);
        e = cyc;
        push(0, 1'b1, 16'h0003, 16'h1234, 16'hBEEF, e + 1, e + 2);
        req[0] = 1'b1;
        wait_done("write", 20);
        step();
        chk("mem_written", {16'd0, mem[8'h03]}, 32'h1234);
        chk("rdata_hold", {16'd0, rdata}, 32'hBEEF);

        // Masking: core 5 disabled with num_cores=3
        num_cores = 6'd3;
        set_core(1, 1'b0, 16'h0020, 16'h0);
        set_core(5, 1'b0, 16'h0025, 16'h0);
        push(1, 1'b0, 16'h0020, 16'h0, 16'h5A5A, -1, -1);
        req[1] = 1'b1;
        req[5] = 1'b1;
        wait_done("mask", 20);
        repeat (12) step();
        chk("mask_req5_pending", {31'd0, req[5]}, 1);
        num_cores = 6'd0;
        repeat (9) step();
        chk("zero_en_idle", {31'd0, busy}, 0);
        // Count above NUM_CORES enables everyone
        num_cores = 6'd40;
        push(5, 1'b0, 16'h0025, 16'h0, 16'h7777, -1, -1);
        wait_done("over_count", 20);
        step();

        // In-flight transaction ignores input changes and disable
        num_cores = 6'd16;
        set_core(4, 1'b0, 16'h0030, 16'h0);
        e = cyc;
        push(4, 1'b0, 16'h0030, 16'h0, 16'h1357, e + 1, e + 2);
        req[4] = 1'b1;
        step();
        set_core(4, 1'b1, 16'h0031, 16'hFFFF);
        num_cores = 6'd0;
        wait_done("inflight", 20);
        step();
        num_cores = 6'd16;

        // Fairness after reset: 0..15 then 0 again, 3 cycles apart
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_core(i, 1'b0, 16'(16'h40 + i), 16'h0);
        drop = 1'b0;
        e = cyc;
        for (int n = 0; n <= N; n++) begin
            push(n % N, 1'b0, 16'(16'h40 + n % N), 16'h0,
                 16'(16'hA040 + n % N), e + 1 + 3*n, e + 2 + 3*n);
        end
        req = '1;
        wait_done("fair", 80);
        req = '0;
        drop = 1'b1;
        repeat (6) step();

        // Async reset in ACCESS aborts with no ack
        set_core(2, 1'b0, 16'h0010, 16'h0);
        req[2] = 1'b1;
        step();
        chk("pre_rst_rd", {31'd0, mem_rd}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_strobes", {30'd0, mem_rd, mem_wr}, 0);
        chk("async_busy", {31'd0, busy}, 0);
        chk("async_ack", {16'd0, ack}, 0);
        chk("async_rdata", {16'd0, rdata}, 0);
        req = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_ack", {16'd0, ack}, 0);
        req[3] = 1'b1;
        req[7] = 1'b1;
        push(3, 1'b0, 16'h0043, 16'h0, 16'hA043, -1, -1);
        push(7, 1'b0, 16'h0047, 16'h0, 16'hA047, -1, -1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_done("post_rst", 30);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
